inv_mix_columns_seq: RTL and testbench

Iterative AES InvMixColumns stage for the decryption datapath. It multiplies each state column by the inverse circulant matrix {0E,0B,0D,09} over GF(2^8), processing one column per clock. It sits between the inverse round-key addition and the InvShiftRows/InvSubBytes stage. It uses the same 128-bit row-major state layout and enable/done pulse handshake as the forward MixColumns stage.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/inv_calculate_column.sv | 26 ++
 rtl/inv_mix_columns_seq.sv | 131 +++++++++++++
 tb/tb_inv_mix_columns_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, the inverse-column FSM state type and GF(2^8) helpers.
// Used by inv_mix_columns_seq (optional feature macro: INV_MIX_BYPASS_EN).
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_COL_W   = 32;

    localparam logic [7:0] AES_POLY   = 8'h1B;
    localparam logic [7:0] INV_MIX_C0 = 8'h0E;
    localparam logic [7:0] INV_MIX_C1 = 8'h0B;
    localparam logic [7:0] INV_MIX_C2 = 8'h0D;
    localparam logic [7:0] INV_MIX_C3 = 8'h09;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } inv_mix_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Multiply by one of the four inverse-matrix coefficients using chained xtime.
    function automatic logic [7:0] gf_mul_inv_coef(input logic [7:0] b, input logic [7:0] coef);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        logic [7:0] res;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (coef)
            INV_MIX_C0: res = x8 ^ x4 ^ x2;
            INV_MIX_C1: res = x8 ^ x2 ^ b;
            INV_MIX_C2: res = x8 ^ x4 ^ b;
            INV_MIX_C3: res = x8 ^ b;
            default:    res = 8'h00;
        endcase
        return res;
    endfunction

    // Column c of a row-major state, row 0 in the top byte.
    function automatic logic [AES_COL_W-1:0] get_column(input logic [AES_STATE_W-1:0] st,
                                                         input logic [1:0]             c);
        logic [AES_COL_W-1:0] col_v;
        col_v = 32'h0000_0000;
        for (int r = 0; r < 4; r++) begin
            col_v[31-8*r -: 8] = st[127-32*r-8*int'(c) -: 8];
        end
        return col_v;
    endfunction

    function automatic logic [AES_STATE_W-1:0] set_column(input logic [AES_STATE_W-1:0] st,
                                                           input logic [1:0]             c,
                                                           input logic [AES_COL_W-1:0]   col_v);
        logic [AES_STATE_W-1:0] res;
        res = st;
        for (int r = 0; r < 4; r++) begin
            res[127-32*r-8*int'(c) -: 8] = col_v[31-8*r -: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/inv_calculate_column.sv
// Combinational InvMixColumns for one 32-bit column (row 0 in bits [31:24]).
module inv_calculate_column
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] pi_col,
    output logic [AES_COL_W-1:0] po_col
);

    logic [AES_BYTE_W-1:0] a_s [4];
    logic [AES_BYTE_W-1:0] b_s [4];

    // Split the column and apply the circulant {0E,0B,0D,09} row by row.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a_s[r] = pi_col[31-8*r -: 8];
        end
        for (int r = 0; r < 4; r++) begin
            b_s[r] = gf_mul_inv_coef(a_s[r],         INV_MIX_C0)
                   ^ gf_mul_inv_coef(a_s[(r+1) % 4], INV_MIX_C1)
                   ^ gf_mul_inv_coef(a_s[(r+2) % 4], INV_MIX_C2)
                   ^ gf_mul_inv_coef(a_s[(r+3) % 4], INV_MIX_C3);
        end
        po_col = {b_s[0], b_s[1], b_s[2], b_s[3]};
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns, one column per clock, enable/done handshake.
// Optional pass-through for the final round when INV_MIX_BYPASS_EN is defined.
module inv_mix_columns_seq
    import aes_pkg::*;
(
    input  logic                   pi_clk,
    input  logic                   pi_rst,
    input  logic                   pi_enable,
    input  logic [AES_STATE_W-1:0] pi_in,
`ifdef INV_MIX_BYPASS_EN
    input  logic                   pi_bypass,
`endif
    output logic                   po_busy,
    output logic                   po_done,
    output logic [AES_STATE_W-1:0] po_out
);

    inv_mix_state_t         state_q, state_d;
    logic [1:0]             col_q, col_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [AES_STATE_W-1:0] out_q, out_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [AES_COL_W-1:0]   col_in_s;
    logic [AES_COL_W-1:0]   col_calc_s;
    logic [AES_COL_W-1:0]   col_res_s;

    // Single shared column unit, fed with the column selected by col_q.
    inv_calculate_column u_col (
        .pi_col (col_in_s),
        .po_col (col_calc_s)
    );

    assign col_in_s = get_column(work_q, col_q);

`ifdef INV_MIX_BYPASS_EN
    logic bypass_q, bypass_d;

    // Bypass flag is latched alongside the state at capture.
    always_comb begin
        if (state_q == ST_IDLE && pi_enable) begin
            bypass_d = pi_bypass;
        end else begin
            bypass_d = bypass_q;
        end
    end

    // Bypass register.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
        end
    end

    // Bypassed operations write each column back unchanged.
    always_comb begin
        if (bypass_q) begin
            col_res_s = col_in_s;
        end else begin
            col_res_s = col_calc_s;
        end
    end
`else
    // Column result always comes from the InvMixColumns unit.
    always_comb begin
        col_res_s = col_calc_s;
    end
`endif

    // Next-state and datapath updates for the IDLE/CALC sequencer.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pi_enable) begin
                    work_d  = pi_in;
                    col_d   = 2'd0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                work_d = set_column(work_q, col_q, col_res_s);
                col_d  = col_q + 2'd1;
                // Last column: publish the fully transformed state.
                if (col_q == 2'd3) begin
                    out_d   = work_d;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_CALC);
    end

    // State, counter, working and output registers.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            state_q <= ST_IDLE;
            col_q   <= 2'd0;
            work_q  <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
            out_q   <= out_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign po_busy = busy_q;
    assign po_done = done_q;
    assign po_out  = out_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: vector table, handshake corner
// cases and a forward-MixColumns round trip (bypass case when INV_MIX_BYPASS_EN).
module tb_inv_mix_columns_seq;

    logic         pi_clk;
    logic         pi_rst;
    logic         pi_enable;
    logic [127:0] pi_in;
    logic         pi_bypass;
    logic         po_busy;
    logic         po_done;
    logic [127:0] po_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] sb_q[$];

    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
        string        name;
    } vec_t;

    vec_t vecs[4];

    inv_mix_columns_seq dut (
        .pi_clk    (pi_clk),
        .pi_rst    (pi_rst),
        .pi_enable (pi_enable),
        .pi_in     (pi_in),
`ifdef INV_MIX_BYPASS_EN
        .pi_bypass (pi_bypass),
`endif
        .po_busy   (po_busy),
        .po_done   (po_done),
        .po_out    (po_out)
    );

    initial pi_clk = 1'b0;
    always #5 pi_clk = ~pi_clk;

    task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tb_xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1B) : {b[6:0], 1'b0};
    endfunction

    // Forward MixColumns reference (matrix {02,03,01,01}).
    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [7:0]   a[4];
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-32*r-8*c -: 8];
            for (int r = 0; r < 4; r++)
                o[127-32*r-8*c -: 8] = tb_xt(a[r]) ^ tb_xt(a[(r+1)%4]) ^ a[(r+1)%4]
                                     ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
        return o;
    endfunction

    // One start pulse; expects done on the 5th sampling point with 4 busy cycles.
    task automatic do_op(input logic [127:0] din, input logic byp, input logic [127:0] exp,
                         input string name);
        int   n;
        int   busy_n;
        logic seen;
        @(negedge pi_clk);
        pi_in = din; pi_bypass = byp; pi_enable = 1'b1;
        sb_q.push_back(exp);
        n = 0; busy_n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge pi_clk);
            pi_enable = 1'b0;
            n++;
            if (po_busy) busy_n++;
            if (po_done) seen = 1'b1;
        end
        check_int({name, " done_seen"}, int'(seen), 1);
        check_int({name, " latency"}, n, 5);
        check_int({name, " busy_cycles"}, busy_n, 4);
        if (seen) check_vec({name, " out"}, po_out, sb_q.pop_front());
        else void'(sb_q.pop_front());
    endtask

    initial begin
        logic [127:0] prev;
        logic [127:0] x;
        int           n;
        int           dones;
        int           first_at;
        int           hold_bad;

        vecs[0] = '{128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6,
                    128'hdbf201c6_130a01c6_532201c6_455c01c6, "fips"};
        vecs[1] = '{128'hd54d8e01_d57e4d01_d7bda101_d6f8bc01,
                    128'hd42ddb01_d4261301_d4315301_d54c4501, "mixed_cols"};
        vecs[2] = '{128'h0, 128'h0, "zero"};
        vecs[3] = '{128'h12345678_12345678_12345678_12345678,
                    128'h12345678_12345678_12345678_12345678, "const_cols"};

        pi_rst = 1'b1; pi_enable = 1'b0; pi_in = '0; pi_bypass = 1'b0;
        repeat (3) @(negedge pi_clk);
        check_vec("reset out", po_out, 128'h0);
        check_int("reset done", int'(po_done), 0);
        check_int("reset busy", int'(po_busy), 0);
        pi_rst = 1'b0;

        for (int i = 0; i < 4; i++) do_op(vecs[i].din, 1'b0, vecs[i].exp, vecs[i].name);

        // Back-to-back: restart in the done cycle, old result must hold.
        do_op(vecs[0].din, 1'b0, vecs[0].exp, "b2b_first");
        prev = po_out;
        pi_in = 128'h0; pi_enable = 1'b1;
        sb_q.push_back(128'h0);
        n = 0; hold_bad = 0; first_at = 0;
        while (first_at == 0 && n < 20) begin
            @(negedge pi_clk);
            pi_enable = 1'b0;
            n++;
            if (po_done) first_at = n;
            else if (po_out !== prev) hold_bad++;
        end
        check_int("b2b latency", first_at, 5);
        check_int("b2b hold_violations", hold_bad, 0);
        if (first_at != 0) check_vec("b2b out", po_out, sb_q.pop_front());
        else void'(sb_q.pop_front());

        // Starts while busy are ignored.
        @(negedge pi_clk);
        pi_in = vecs[0].din; pi_enable = 1'b1;
        sb_q.push_back(vecs[0].exp);
        dones = 0; first_at = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge pi_clk);
            if (po_done) begin
                dones++;
                if (first_at == 0) first_at = k;
                if (sb_q.size() > 0) check_vec("busy_ignore out", po_out, sb_q.pop_front());
                else check_int("busy_ignore extra_done", 1, 0);
            end
            if (k <= 4) begin
                pi_enable = 1'b1;
                pi_in = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                pi_enable = 1'b0;
            end
        end
        check_int("busy_ignore dones", dones, 1);
        check_int("busy_ignore latency", first_at, 5);
        sb_q.delete();

        // Reset at E2 with a concurrent start discards the operation.
        @(negedge pi_clk);
        pi_in = vecs[1].din; pi_enable = 1'b1;
        @(negedge pi_clk);
        pi_enable = 1'b0;
        @(negedge pi_clk);
        pi_rst = 1'b1; pi_enable = 1'b1;
        @(negedge pi_clk);
        pi_rst = 1'b0; pi_enable = 1'b0;
        check_int("midrst busy", int'(po_busy), 0);
        check_int("midrst done", int'(po_done), 0);
        check_vec("midrst out", po_out, 128'h0);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge pi_clk);
            if (po_done) dones++;
        end
        check_int("midrst no_done", dones, 0);
        do_op(vecs[1].din, 1'b0, vecs[1].exp, "after_rst");

        // Enable held high: captures every fifth edge, one done each.
        @(negedge pi_clk);
        pi_in = vecs[1].din; pi_enable = 1'b1;
        repeat (3) sb_q.push_back(vecs[1].exp);
        dones = 0;
        for (int k = 1; k <= 22; k++) begin
            @(negedge pi_clk);
            if (po_done) begin
                dones++;
                if (sb_q.size() > 0) check_vec("held out", po_out, sb_q.pop_front());
                else check_int("held extra_done", 1, 0);
            end
            if (k == 15) pi_enable = 1'b0;
        end
        check_int("held dones", dones, 3);
        sb_q.delete();

`ifdef INV_MIX_BYPASS_EN
        do_op(vecs[0].din, 1'b1, vecs[0].din, "bypass");
        do_op(vecs[0].din, 1'b0, vecs[0].exp, "post_bypass");
`endif

        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            do_op(fwd_mix(x), 1'b0, x, "roundtrip");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
